// File: rtl/pocket_synth_voices.sv
// Polyphonic square-wave synth: NUM_VOICES oscillators with 4-bit amplitude, summed into a first-order sigma-delta pin.
// keys->leds 2 cycles, level->audio_out 1 cycle, no backpressure; `define SYNTH_ENVELOPE_EN for timed attack/release.
module pocket_synth_voices #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int NUM_VOICES = 4,
   parameter int HALF_W     = 24,
   parameter int ENV_DIV    = 50_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_VOICES-1:0] keys,
   input  logic                  cfg_we,
   input  logic [2:0]            cfg_addr,
   input  logic [HALF_W-1:0]     cfg_wdata,
   output logic                  audio_out,
   output logic [NUM_VOICES-1:0] leds,
   output logic [NUM_VOICES-1:0] voice_active
);
   localparam int             FULL   = NUM_VOICES * 15;
   localparam int             LVL_W  = $clog2(FULL + 1);
   localparam logic [LVL_W:0] FULL_S = (LVL_W + 1)'(FULL);

   if (NUM_VOICES < 1 || NUM_VOICES > 8 || ENV_DIV < 1) begin : g_param_check
      $error("pocket_synth_voices: NUM_VOICES must be 1..8 and ENV_DIV >= 1");
   end

   // Power-up half-periods: C4 D4 E4 F4 G4 A4 B4 C5.
   function automatic logic [HALF_W-1:0] reset_half(input int idx);
      int freq;
      case (idx)
         0:       freq = 262;
         1:       freq = 294;
         2:       freq = 330;
         3:       freq = 349;
         4:       freq = 392;
         5:       freq = 440;
         6:       freq = 494;
         default: freq = 523;
      endcase
      return HALF_W'(CLK_FREQ / (2 * freq));
   endfunction

   logic [NUM_VOICES-1:0] key_m;
   logic [NUM_VOICES-1:0] key_s;
   logic [HALF_W-1:0]     half [NUM_VOICES];
   logic [HALF_W-1:0]     ctr  [NUM_VOICES];
   logic [3:0]            amp  [NUM_VOICES];
   logic [NUM_VOICES-1:0] tone;
   logic [LVL_W-1:0]      mix_sum;
   logic [LVL_W-1:0]      level;
   logic [LVL_W-1:0]      acc;
   logic [LVL_W:0]        sd_sum;

`ifdef SYNTH_ENVELOPE_EN
   localparam int DIV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
   logic [DIV_W-1:0] env_cnt;
   logic             env_tick;

   assign env_tick = (env_cnt == DIV_W'(ENV_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        env_cnt <= '0;
      else if (env_tick) env_cnt <= '0;
      else               env_cnt <= env_cnt + DIV_W'(1);
   end
`endif

   assign leds = key_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_m        <= '0;
         key_s        <= '0;
         voice_active <= '0;
         tone         <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            half[i] <= reset_half(i);
            ctr[i]  <= '0;
            amp[i]  <= '0;
         end
      end else begin
         key_m <= keys;
         key_s <= key_m;
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (cfg_we && cfg_addr == 3'(i)) half[i] <= cfg_wdata;
`ifdef SYNTH_ENVELOPE_EN
            if (env_tick) begin
               if (key_s[i] && amp[i] != 4'd15)      amp[i] <= amp[i] + 4'd1;
               else if (!key_s[i] && amp[i] != 4'd0) amp[i] <= amp[i] - 4'd1;
            end
            voice_active[i] <= key_s[i] | (amp[i] != 4'd0);
`else
            amp[i]          <= key_s[i] ? 4'd15 : 4'd0;
            voice_active[i] <= key_s[i];
`endif
            // Compare uses the pre-write half, so a shrink below ctr toggles next cycle.
            if (!voice_active[i] || half[i] == '0) begin
               ctr[i]  <= '0;
               tone[i] <= 1'b0;
            end else if (ctr[i] >= half[i] - HALF_W'(1)) begin
               ctr[i]  <= '0;
               tone[i] <= ~tone[i];
            end else begin
               ctr[i]  <= ctr[i] + HALF_W'(1);
            end
         end
      end
   end

   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (tone[i]) mix_sum = mix_sum + LVL_W'(amp[i]);
      end
   end

   assign sd_sum = {1'b0, acc} + {1'b0, level};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level     <= '0;
         acc       <= '0;
         audio_out <= 1'b0;
      end else begin
         level <= mix_sum;
         if (sd_sum >= FULL_S) begin
            audio_out <= 1'b1;
            acc       <= LVL_W'(sd_sum - FULL_S);
         end else begin
            audio_out <= 1'b0;
            acc       <= LVL_W'(sd_sum);
         end
      end
   end
endmodule

// File: tb/tb_pocket_synth_voices.sv
// Self-checking bench for pocket_synth_voices: table vectors, directed corner sequences, randomized run vs reference model.
module tb_pocket_synth_voices;
   localparam int NV   = 4;
   localparam int HW   = 24;
   localparam int EDIV = 4;
   localparam int FULL = NV * 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NV-1:0] keys;
   logic          cfg_we;
   logic [2:0]    cfg_addr;
   logic [HW-1:0] cfg_wdata;
   logic          audio_out;
   logic [NV-1:0] leds;
   logic [NV-1:0] voice_active;

   int checks = 0;
   int errors = 0;

   pocket_synth_voices #(
      .CLK_FREQ(50_000_000), .NUM_VOICES(NV), .HALF_W(HW), .ENV_DIV(EDIV)
   ) dut (
      .clk(clk), .rst_n(rst_n), .keys(keys), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .audio_out(audio_out), .leds(leds), .voice_active(voice_active)
   );

   always #5 clk = ~clk;

   // Reference model: note frequencies, per-voice state as plain integers.
   int      freq_tab [8] = '{262, 294, 330, 349, 392, 440, 494, 523};
   int      m_half [NV];
   int      m_ctr  [NV];
   int      m_amp  [NV];
   bit      m_tone [NV];
   bit [NV-1:0] m_k1, m_ks, m_act;
   int      m_level, m_acc, m_pre;
   bit      m_audio;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_k1 = '0; m_ks = '0; m_act = '0;
      m_level = 0; m_acc = 0; m_pre = 0; m_audio = 1'b0;
      for (int i = 0; i < NV; i++) begin
         m_half[i] = 50_000_000 / (2 * freq_tab[i]);
         m_ctr[i]  = 0;
         m_amp[i]  = 0;
         m_tone[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      int lvl, s;
      bit tick;
      lvl = 0;
      for (int i = 0; i < NV; i++) if (m_tone[i]) lvl += m_amp[i];
      s       = m_acc + m_level;
      m_audio = (s >= FULL);
      m_acc   = m_audio ? s - FULL : s;
      m_level = lvl;
      tick    = (m_pre == EDIV - 1);
      m_pre   = tick ? 0 : m_pre + 1;
      for (int i = 0; i < NV; i++) begin
         if (!m_act[i] || m_half[i] == 0) begin
            m_ctr[i] = 0; m_tone[i] = 1'b0;
         end else if (m_ctr[i] + 1 >= m_half[i]) begin
            m_ctr[i] = 0; m_tone[i] = !m_tone[i];
         end else begin
            m_ctr[i]++;
         end
         if (cfg_we && int'(cfg_addr) == i) m_half[i] = int'(cfg_wdata);
`ifdef SYNTH_ENVELOPE_EN
         m_act[i] = m_ks[i] || (m_amp[i] > 0);
         if (tick) m_amp[i] = m_ks[i] ? ((m_amp[i] < 15) ? m_amp[i] + 1 : 15)
                                      : ((m_amp[i] > 0) ? m_amp[i] - 1 : 0);
`else
         m_act[i] = m_ks[i];
         m_amp[i] = m_ks[i] ? 15 : 0;
`endif
      end
      m_ks = m_k1;
      m_k1 = keys;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step(); else model_reset();
      #1;
      check("audio_out", audio_out, m_audio);
      check("leds", leds, m_ks);
      check("voice_active", voice_active, m_act);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic cfg_write(input int addr, input int data);
      cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_wdata = HW'(data);
      cycle();
      cfg_we = 1'b0;
   endtask

   typedef struct {
      logic [NV-1:0] keys;
      logic          we;
      logic [2:0]    addr;
      logic [HW-1:0] data;
      logic [NV-1:0] exp_leds;
      int            idx;
      int            exp_half;
   } vec_t;

   vec_t tab [6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n, ones;
      bit found;
      logic t0;

      tab[0] = '{4'b0010, 1'b1, 3'd1, 24'd5,   4'b0010, 1, 5};
      tab[1] = '{4'b0010, 1'b1, 3'd5, 24'd7,   4'b0010, 1, 5};
      tab[2] = '{4'b1000, 1'b1, 3'd4, 24'd9,   4'b1000, 0, 95419};
      tab[3] = '{4'b0101, 1'b1, 3'd2, 24'd0,   4'b0101, 2, 0};
      tab[4] = '{4'b1111, 1'b0, 3'd3, 24'd123, 4'b1111, 3, 71633};
      tab[5] = '{4'b0000, 1'b1, 3'd3, 24'd100, 4'b0000, 3, 100};

      rst_n = 1'b0; keys = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      model_reset();
      run(3);
      check("reset_audio", audio_out, 0);
      check("reset_leds", leds, 0);
      check("reset_active", voice_active, 0);
      check("reset_half0", dut.half[0], 95419);
      check("reset_half1", dut.half[1], 85034);
      rst_n = 1'b1;
      run(2);

      // Config writes (incl. out-of-range addresses) and key synchronisation.
      for (int v = 0; v < 6; v++) begin
         keys = tab[v].keys; cfg_we = tab[v].we; cfg_addr = tab[v].addr; cfg_wdata = tab[v].data;
         cycle();
         cfg_we = 1'b0;
         run(3);
         check("tab_leds", leds, tab[v].exp_leds);
         check("tab_half", dut.half[tab[v].idx], tab[v].exp_half);
      end
      run(80);

      // Period with half[1]=5.
      keys = 4'b0010;
      n = 0;
      while (!voice_active[1] && n < 20) begin cycle(); n++; end
      check("v1_active_rise", voice_active[1], 1);
      n = 0;
      while (!dut.tone[1] && n < 20) begin cycle(); n++; end
      check("v1_first_toggle", n, 5);
      n = 0;
      while (dut.tone[1] && n < 20) begin cycle(); n++; end
      check("v1_high_len", n, 5);
      n = 0;
      while (!dut.tone[1] && n < 20) begin cycle(); n++; end
      check("v1_low_len", n, 5);
      check("v1_leds", leds, 4'b0010);

`ifdef SYNTH_ENVELOPE_EN
      keys = '0; run(80);
      cfg_write(0, 3);
      keys = 4'b0001;
      n = 0;
      while (dut.amp[0] != 4'd15 && n < 100) begin cycle(); n++; end
      check("attack_time_in_range", (n >= 58 && n <= 63), 1);
      run(8);
      check("attack_holds_15", dut.amp[0], 15);
      keys = 4'b0000;
      n = 0;
      while (voice_active[0] && n < 100) begin cycle(); n++; end
      check("release_time_in_range", (n >= 59 && n <= 64), 1);
      check("release_amp_zero", dut.amp[0], 0);
      cycle();
      check("release_tone_zero", dut.tone[0], 0);
`else
      keys = 4'b0001; run(10);
      keys = 4'b0000;
      cycle(); check("rel_active_c1", voice_active[0], 1);
      cycle(); check("rel_active_c2", voice_active[0], 1);
      cycle(); check("rel_active_c3", voice_active[0], 0);
      check("rel_amp_c3", dut.amp[0], 0);
      cycle(); check("rel_tone_c4", dut.tone[0], 0);
`endif

      // Sigma-delta density: one voice at full, then all four.
      keys = '0; run(80);
      cfg_write(0, 200);
      keys = 4'b0001;
      found = 0;
      for (int k = 0; k < 400 && !found; k++) begin cycle(); found = m_tone[0]; end
      check("density1_tone_wait", found, 1);
      run(5);
      ones = 0;
      for (int k = 0; k < 100; k++) begin cycle(); ones += int'(audio_out); end
      check("density1_ones", ones, 25);

      keys = '0; run(80);
      for (int i = 0; i < NV; i++) cfg_write(i, 200);
      keys = 4'b1111;
      found = 0;
      for (int k = 0; k < 400 && !found; k++) begin cycle(); found = m_tone[0]; end
      check("density4_tone_wait", found, 1);
      run(5);
      ones = 0;
      for (int k = 0; k < 100; k++) begin cycle(); ones += int'(audio_out); end
      check("density4_ones", ones, 100);

      // Reset mid-note.
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_audio", audio_out, 0);
      check("midrst_leds", leds, 0);
      check("midrst_active", voice_active, 0);
      model_reset();
      check("midrst_half0", dut.half[0], 95419);
      check("midrst_half3", dut.half[3], 71633);
      run(2);
      rst_n = 1'b1;
      run(2);

      // Zero half-period.
      cfg_write(2, 0);
      keys = 4'b0100;
      run(10);
      for (int k = 0; k < 20; k++) begin
         cycle();
         check("zero_half_tone", dut.tone[2], 0);
         check("zero_half_level", dut.level, 0);
         check("zero_half_active", voice_active[2], 1);
      end

      // Mid-note shrink.
      keys = '0; run(80);
      cfg_write(3, 100);
      keys = 4'b1000;
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         cycle();
         found = (m_act[3] && m_ctr[3] == 50);
      end
      check("shrink_wait", found, 1);
      check("shrink_ctr50", dut.ctr[3], 50);
      t0 = dut.tone[3];
      cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 24'd2;
      cycle();
      cfg_we = 1'b0;
      check("shrink_c0", dut.tone[3], t0);
      cycle(); check("shrink_c1", dut.tone[3], !t0);
      cycle(); check("shrink_c2", dut.tone[3], !t0);
      cycle(); check("shrink_c3", dut.tone[3], t0);
      cycle(); check("shrink_c4", dut.tone[3], t0);
      cycle(); check("shrink_c5", dut.tone[3], !t0);

      // Randomized keys and config writes against the model.
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 7) == 0) keys = NV'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            cfg_we = 1'b1; cfg_addr = 3'($urandom_range(0, 7)); cfg_wdata = HW'($urandom_range(0, 12));
         end
         cycle();
         cfg_we = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
